// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the pipeline stall/flush sequencer (state enum, XZR, drain depth, source-match helper)
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED, FAULT} state_e;
  localparam logic [4:0] XZR = 5'd31;
  localparam logic [1:0] DRAIN_DEPTH = 2'd3;
  function automatic logic src_hit(input logic use_r, input logic [4:0] rs, input logic [4:0] rd);
    return use_r && rs == rd;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side bundle; master drives ID/EX/MEM hazard info, branch, memory handshake and halt_req, slave drives stage enables, bubbles/flush and halted/fault status
interface pipe_hazard_ctrl_if;
  logic [4:0] Rn_IF_ID, Rm_IF_ID, Rd_ID_EX, Rd_EX_MEM;
  logic use_rn, use_rm, MemRead_ID_EX, MemRead_EX_MEM, branch_taken_id, mem_access, mem_ready, halt_req;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble, mem_wb_bubble, halted, fault;
  modport master (
    output Rn_IF_ID, Rm_IF_ID, Rd_ID_EX, Rd_EX_MEM, use_rn, use_rm, MemRead_ID_EX, MemRead_EX_MEM,
           branch_taken_id, mem_access, mem_ready, halt_req,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble, mem_wb_bubble, halted, fault
  );
  modport slave (
    input  Rn_IF_ID, Rm_IF_ID, Rd_ID_EX, Rd_EX_MEM, use_rn, use_rm, MemRead_ID_EX, MemRead_EX_MEM,
           branch_taken_id, mem_access, mem_ready, halt_req,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble, mem_wb_bubble, halted, fault
  );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use check of ID sources (rn, rm, use_rn, use_rm) against loads in EX/MEM (rd_ex, rd_mem, mem_read_ex, mem_read_mem); outputs hz_ex, hz_mem, lu
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] rn,
  input  logic [4:0] rm,
  input  logic       use_rn,
  input  logic       use_rm,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rd_mem,
  input  logic       mem_read_ex,
  input  logic       mem_read_mem,
  output logic       hz_ex,
  output logic       hz_mem,
  output logic       lu
);
  always_comb begin
    hz_ex = mem_read_ex && rd_ex != XZR && (src_hit(use_rn, rn, rd_ex) || src_hit(use_rm, rm, rd_ex));
    hz_mem = mem_read_mem && rd_mem != XZR && (src_hit(use_rn, rn, rd_mem) || src_hit(use_rm, rm, rd_mem));
    lu = hz_ex || hz_mem;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/drain/halt sequencer; ports clk, rst (async high), bus (pipe_hazard_ctrl_if.slave), stall_cycles/flush_count/memwait_cycles (CNT_W, built only with PIPE_PERF_CNT_EN)
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] memwait_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic hz_ex, hz_mem, lu, memwait, timeout;
  logic flt, mw, hold, stl, drn, brf;
  hazard_detect u_hazard_detect (
    .rn(bus.Rn_IF_ID),
    .rm(bus.Rm_IF_ID),
    .use_rn(bus.use_rn),
    .use_rm(bus.use_rm),
    .rd_ex(bus.Rd_ID_EX),
    .rd_mem(bus.Rd_EX_MEM),
    .mem_read_ex(bus.MemRead_ID_EX),
    .mem_read_mem(bus.MemRead_EX_MEM),
    .hz_ex(hz_ex),
    .hz_mem(hz_mem),
    .lu(lu)
  );
  hz_consistent: assert property (@(posedge clk) lu == (hz_ex || hz_mem));
  always_comb begin
    memwait = bus.mem_access && !bus.mem_ready;
    timeout = memwait && wait_cnt_q == WW'(MEM_TIMEOUT - 1);
    wait_cnt_d = memwait ? wait_cnt_q + WW'(1) : '0;
    state_d = state_q;
    drain_d = drain_q;
    if (timeout) state_d = FAULT;
    else if (state_q == RUN && bus.halt_req && !memwait && !lu && !bus.branch_taken_id) begin
      state_d = DRAIN;
      drain_d = DRAIN_DEPTH;
    end else if (state_q == DRAIN && !memwait) begin
      drain_d = drain_q - 2'd1;
      state_d = drain_q == 2'd1 ? HALTED : DRAIN;
    end else if (state_q == HALTED && !bus.halt_req) state_d = RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wait_cnt_q <= wait_cnt_d;
    end
  always_comb begin
    flt = !rst && state_q == FAULT;
    mw = !rst && !flt && memwait;
    hold = !rst && !flt && !mw && state_q == HALTED;
    stl = !rst && !flt && !mw && !hold && lu;
    drn = !rst && !flt && !mw && !stl && state_q == DRAIN;
    brf = !rst && !flt && !mw && !stl && state_q == RUN && bus.branch_taken_id;
    bus.pc_en = !(flt || mw || hold || stl || drn);
    bus.if_id_en = !(flt || mw || hold || stl);
    bus.id_ex_en = !(flt || mw);
    bus.ex_mem_en = !(flt || mw);
    bus.if_id_flush = flt || hold || drn || brf;
    bus.id_ex_bubble = flt || stl;
    bus.mem_wb_bubble = flt || mw;
    bus.halted = state_q == HALTED;
    bus.fault = state_q == FAULT;
  end
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d, mwc_q, mwc_d;
  always_comb begin
    stall_d = lu && !memwait && !(&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = brf && !(&flush_q) ? flush_q + CNT_W'(1) : flush_q;
    mwc_d = memwait && !(&mwc_q) ? mwc_q + CNT_W'(1) : mwc_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      mwc_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      mwc_q <= mwc_d;
    end
  assign stall_cycles = stall_q;
  assign flush_count = flush_q;
  assign memwait_cycles = mwc_q;
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
  assign memwait_cycles = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (expected control/counter values queued by stimulus, checked by a negedge monitor)
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] stall_cycles, flush_count, memwait_cycles;
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count),
    .memwait_cycles(memwait_cycles)
  );
  always #5 clk = ~clk;
  typedef struct {
    string nm;
    int kind;
    logic [31:0] exp;
  } item_t;
  item_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  localparam logic [8:0] NORM = 9'b1111_000_00;
  localparam logic [8:0] LU   = 9'b0011_010_00;
  localparam logic [8:0] MW   = 9'b0000_001_00;
  localparam logic [8:0] BR   = 9'b1111_100_00;
  localparam logic [8:0] DRN  = 9'b0111_100_00;
  localparam logic [8:0] HLT  = 9'b0011_100_10;
  localparam logic [8:0] FLT  = 9'b0000_111_01;
  function automatic logic [31:0] ce(input int v);
`ifdef PIPE_PERF_CNT_EN
    return 32'(v);
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction
  task automatic idle_in();
    bus.Rn_IF_ID = '0;
    bus.Rm_IF_ID = '0;
    bus.Rd_ID_EX = '0;
    bus.Rd_EX_MEM = '0;
    bus.use_rn = 1'b0;
    bus.use_rm = 1'b0;
    bus.MemRead_ID_EX = 1'b0;
    bus.MemRead_EX_MEM = 1'b0;
    bus.branch_taken_id = 1'b0;
    bus.mem_access = 1'b0;
    bus.mem_ready = 1'b0;
    bus.halt_req = 1'b0;
  endtask
  task automatic load_use(input logic [4:0] r);
    bus.MemRead_ID_EX = 1'b1;
    bus.Rd_ID_EX = r;
    bus.Rn_IF_ID = r;
    bus.use_rn = 1'b1;
  endtask
  task automatic step(input string nm, input logic [8:0] e);
    q.push_back('{nm, 0, {23'd0, e}});
    @(posedge clk);
    #1;
  endtask
  task automatic cnt(input string nm, input int k, input int v);
    q.push_back('{nm, k, ce(v)});
  endtask
  always @(negedge clk) begin
    item_t it;
    logic [31:0] act;
    while (q.size() > 0) begin
      it = q.pop_front();
      act = it.kind == 0 ? {23'd0, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.if_id_flush,
                            bus.id_ex_bubble, bus.mem_wb_bubble, bus.halted, bus.fault}
          : it.kind == 1 ? stall_cycles
          : it.kind == 2 ? flush_count : memwait_cycles;
      n_chk++;
      if (act === it.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", it.nm, act, it.exp);
    end
  end
  initial begin
    idle_in();
    load_use(5'd1);
    @(posedge clk);
    #1;
    cnt("rst_stall_cnt", 1, 0);
    step("rst_hold", NORM);
    rst = 1'b0;
    idle_in();
    step("idle", NORM);
    load_use(5'd1);
    step("lu_ex", LU);
    bus.MemRead_ID_EX = 1'b0;
    bus.Rd_ID_EX = '0;
    bus.MemRead_EX_MEM = 1'b1;
    bus.Rd_EX_MEM = 5'd1;
    step("lu_mem", LU);
    bus.MemRead_EX_MEM = 1'b0;
    bus.Rd_EX_MEM = '0;
    cnt("stall_2", 1, 2);
    step("lu_clear", NORM);
    idle_in();
    bus.Rm_IF_ID = 5'd2;
    bus.MemRead_ID_EX = 1'b1;
    bus.Rd_ID_EX = 5'd2;
    step("rm_unused", NORM);
    bus.use_rm = 1'b1;
    step("rm_ex", LU);
    idle_in();
    load_use(5'd31);
    step("xzr_ex", NORM);
    bus.MemRead_ID_EX = 1'b0;
    bus.MemRead_EX_MEM = 1'b1;
    bus.Rd_EX_MEM = 5'd31;
    step("xzr_mem", NORM);
    bus.Rd_EX_MEM = 5'd4;
    bus.Rn_IF_ID = 5'd5;
    step("diff_reg", NORM);
    idle_in();
    bus.branch_taken_id = 1'b1;
    step("br_flush", BR);
    cnt("flush_1", 2, 1);
    load_use(5'd3);
    step("br_lu", LU);
    bus.MemRead_ID_EX = 1'b0;
    step("br_after_lu", BR);
    idle_in();
    cnt("flush_2", 2, 2);
    cnt("stall_4", 1, 4);
    step("br_done", NORM);
    bus.mem_access = 1'b1;
    for (int i = 0; i < 4; i++) step("mw4", MW);
    bus.mem_ready = 1'b1;
    step("mw_done", NORM);
    idle_in();
    cnt("memwait_4", 3, 4);
    step("mw_idle", NORM);
    bus.mem_access = 1'b1;
    load_use(5'd6);
    step("mw_over_lu", MW);
    idle_in();
    bus.mem_access = 1'b1;
    bus.mem_ready = 1'b1;
    step("mr_first", NORM);
    idle_in();
    cnt("memwait_5", 3, 5);
    cnt("stall_still_4", 1, 4);
    bus.halt_req = 1'b1;
    load_use(5'd7);
    step("halt_blk_lu", LU);
    idle_in();
    bus.halt_req = 1'b1;
    bus.branch_taken_id = 1'b1;
    step("halt_blk_br", BR);
    bus.branch_taken_id = 1'b0;
    step("halt_enter", NORM);
    for (int i = 0; i < 3; i++) step("drain", DRN);
    step("halted", HLT);
    step("halted_hold", HLT);
    bus.halt_req = 1'b0;
    step("halt_release", HLT);
    cnt("flush_3", 2, 3);
    step("resume", NORM);
    bus.halt_req = 1'b1;
    step("halt2", NORM);
    bus.halt_req = 1'b0;
    for (int i = 0; i < 3; i++) step("drain_drop", DRN);
    step("halt2_done", HLT);
    step("resume2", NORM);
    bus.halt_req = 1'b1;
    step("halt3", NORM);
    step("drain3a", DRN);
    bus.mem_access = 1'b1;
    step("drain_mw", MW);
    bus.mem_access = 1'b0;
    step("drain3b", DRN);
    step("drain3c", DRN);
    step("halted3", HLT);
    bus.halt_req = 1'b0;
    step("halted3_rel", HLT);
    cnt("memwait_6", 3, 6);
    step("resume3", NORM);
    bus.halt_req = 1'b1;
    step("halt4", NORM);
    bus.halt_req = 1'b0;
    step("drain4", DRN);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step("rst_pulse", NORM);
    cnt("stall_rst", 1, 0);
    cnt("flush_rst", 2, 0);
    step("post_rst", NORM);
    bus.mem_access = 1'b1;
    for (int i = 0; i < 14; i++) step("mw14", MW);
    bus.mem_ready = 1'b1;
    step("no_fault_14", NORM);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("mw15", MW);
    step("fault", FLT);
    bus.mem_access = 1'b0;
    bus.halt_req = 1'b1;
    step("fault_hold", FLT);
    cnt("memwait_30", 3, 30);
    step("fault_hold2", FLT);
    idle_in();
    rst = 1'b1;
    step("fault_rst", NORM);
    rst = 1'b0;
    step("after_fault", NORM);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
